spi_reg_ctrl: RTL and testbench

Byte-level sequencer placed behind the CPHA=0 SPI slave receiver. It turns the received byte stream into register-bus transactions and feeds transmit bytes back to the slave's shift register. Each SSEL frame is a command byte followed by any number of data bytes, with address auto-increment. The core is the 7-bit register space shared by the FPGA control logic of the FRDM/i.MX6UL top level.

---
 rtl/spi_reg_ctrl_if.sv | 33 +++
 rtl/spi_reg_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Bundle for spi_reg_ctrl: the SPI slave byte handshake on one side and the
// register bus on the other. The controller uses the slave modport; whatever
// drives the bytes and owns the register file uses the master modport.
interface spi_reg_ctrl_if;
    // Byte stream from the SPI slave receiver
    logic       ssel_active;
    logic       rx_valid;
    logic [7:0] rx_data;

    // Transmit byte back to the slave shift register
    logic [7:0] tx_data;
    logic       tx_load;

    // Register bus
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    // Frame ended right after the command byte
    logic       frame_err;

    modport slave (
        input  ssel_active, rx_valid, rx_data, reg_rdata,
        output tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, frame_err
    );

    modport master (
        output ssel_active, rx_valid, rx_data, reg_rdata,
        input  tx_data, tx_load, reg_addr, reg_wdata, reg_we, reg_re, frame_err
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Byte sequencer between the CPHA=0 SPI slave and the 7-bit register space.
// Each SSEL frame is {rw, addr[6:0]} followed by data bytes; writes are issued
// per byte, reads are prefetched so the next MISO byte is ready in time.
// All outputs are registered; the FSM computes their next values combinationally.
module spi_reg_ctrl #(
    parameter logic [7:0] IDLE_BYTE = 8'hA5,
    parameter bit         AUTO_INC  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_FETCH,
        S_RD_LOAD,
        S_RD_DATA
    } state_t;

    state_t     state, state_nxt;

    // Previous ssel level for frame-start edge detection
    logic       ssel_q;

    // Set once a data (or dummy) byte has been seen in the current frame
    logic       got_data, got_data_nxt;

    // Registered outputs and their next values
    logic [7:0] tx_data_q,   tx_data_nxt;
    logic       tx_load_q,   tx_load_nxt;
    logic [6:0] reg_addr_q,  reg_addr_nxt;
    logic [7:0] reg_wdata_q, reg_wdata_nxt;
    logic       reg_we_q,    reg_we_nxt;
    logic       reg_re_q,    reg_re_nxt;
    logic       frame_err_q, frame_err_nxt;

    logic       frame_start;

    assign frame_start = bus.ssel_active && !ssel_q;

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt     = state;
        got_data_nxt  = got_data;
        tx_data_nxt   = tx_data_q;
        tx_load_nxt   = 1'b0;
        reg_addr_nxt  = reg_addr_q;
        reg_wdata_nxt = reg_wdata_q;
        reg_we_nxt    = 1'b0;
        reg_re_nxt    = 1'b0;
        frame_err_nxt = 1'b0;

        // Write auto-increment lands in the cycle after the strobe, so the
        // address stays stable while reg_we is high.
        if (AUTO_INC && reg_we_q) begin
            reg_addr_nxt = reg_addr_q + 7'd1;
        end

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt    = S_CMD;
                    tx_data_nxt  = IDLE_BYTE;
                    tx_load_nxt  = 1'b1;
                    got_data_nxt = 1'b0;
                end
            end

            S_CMD: begin
                if (bus.rx_valid) begin
                    reg_addr_nxt = bus.rx_data[6:0];
                    if (bus.rx_data[7]) begin
                        // Read: strobe the bus right away so the first byte
                        // is loaded two cycles after the command.
                        state_nxt  = S_RD_FETCH;
                        reg_re_nxt = 1'b1;
                    end else begin
                        state_nxt  = S_WR_DATA;
                    end
                end
            end

            S_WR_DATA: begin
                if (bus.rx_valid) begin
                    reg_wdata_nxt = bus.rx_data;
                    reg_we_nxt    = 1'b1;
                    got_data_nxt  = 1'b1;
                end
            end

            S_RD_FETCH: begin
                // reg_re is high in this cycle and the register file returns
                // the data now; capture it for the slave shift register.
                state_nxt   = S_RD_LOAD;
                tx_data_nxt = bus.reg_rdata;
                tx_load_nxt = 1'b1;
            end

            S_RD_LOAD: begin
                state_nxt = S_RD_DATA;
            end

            S_RD_DATA: begin
                // The received byte is a dummy clocked in while ours went out.
                if (bus.rx_valid) begin
                    got_data_nxt = 1'b1;
                    state_nxt    = S_RD_FETCH;
                    reg_re_nxt   = 1'b1;
                    if (AUTO_INC) begin
                        reg_addr_nxt = reg_addr_q + 7'd1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Frame end wins over everything except a write already accepted
        // this cycle: pending reads and transmit loads are cancelled.
        if (!bus.ssel_active && state != S_IDLE) begin
            state_nxt   = S_IDLE;
            reg_re_nxt  = 1'b0;
            tx_load_nxt = 1'b0;
            tx_data_nxt = tx_data_q;
            if (state == S_CMD) begin
                // Command byte arriving together with the frame drop.
                frame_err_nxt = bus.rx_valid;
            end else begin
                frame_err_nxt = !got_data_nxt;
            end
        end
    end

    // State, edge detector and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: asynchronous reset brings every output to its idle value without waiting for a clock.
        if (!rst_n) begin
            state       <= S_IDLE;
            ssel_q      <= 1'b0;
            got_data    <= 1'b0;
            tx_data_q   <= IDLE_BYTE;
            tx_load_q   <= 1'b0;
            reg_addr_q  <= 7'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            state       <= state_nxt;
            ssel_q      <= bus.ssel_active;
            got_data    <= got_data_nxt;
            tx_data_q   <= tx_data_nxt;
            tx_load_q   <= tx_load_nxt;
            reg_addr_q  <= reg_addr_nxt;
            reg_wdata_q <= reg_wdata_nxt;
            reg_we_q    <= reg_we_nxt;
            reg_re_q    <= reg_re_nxt;
            frame_err_q <= frame_err_nxt;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_load   = tx_load_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl. Two instances: dut_a with AUTO_INC=1,
// dut_b with AUTO_INC=0; only one receives frames at a time. Expected bus
// writes, reads and transmit loads are queued as stimulus is driven and
// compared as the DUT strobes them.
module tb_spi_reg_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       ssel     = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       use_b    = 1'b0;

    logic [7:0] regs [128];
    logic [7:0] shadow [128];

    spi_reg_ctrl_if bus_a ();
    spi_reg_ctrl_if bus_b ();

    spi_reg_ctrl #(.IDLE_BYTE(8'hA5), .AUTO_INC(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    spi_reg_ctrl #(.IDLE_BYTE(8'hA5), .AUTO_INC(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    assign bus_a.ssel_active = ssel & ~use_b;
    assign bus_a.rx_valid    = rx_valid & ~use_b;
    assign bus_a.rx_data     = rx_data;
    assign bus_a.reg_rdata   = regs[bus_a.reg_addr];

    assign bus_b.ssel_active = ssel & use_b;
    assign bus_b.rx_valid    = rx_valid & use_b;
    assign bus_b.rx_data     = rx_data;
    assign bus_b.reg_rdata   = regs[bus_b.reg_addr];

    // Register file written by whichever DUT strobes reg_we
    always @(posedge clk) begin
        if (bus_a.reg_we) regs[bus_a.reg_addr] <= bus_a.reg_wdata;
        if (bus_b.reg_we) regs[bus_b.reg_addr] <= bus_b.reg_wdata;
    end

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    int err_exp  = 0;

    logic [14:0] exp_we [$];  // {addr, data}
    logic [6:0]  exp_re [$];
    logic [7:0]  exp_tx [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic observe(input logic we, input logic re, input logic ld, input logic err,
                           input logic [6:0] addr, input logic [7:0] wd, input logic [7:0] td);
        logic [14:0] e;
        if (we) begin
            check("we_expected", 32'(exp_we.size() > 0), 32'd1);
            if (exp_we.size() > 0) begin
                e = exp_we.pop_front();
                check("we_addr", 32'(addr), 32'(e[14:8]));
                check("we_data", 32'(wd), 32'(e[7:0]));
            end
        end
        if (re) begin
            check("re_expected", 32'(exp_re.size() > 0), 32'd1);
            if (exp_re.size() > 0) check("re_addr", 32'(addr), 32'(exp_re.pop_front()));
        end
        if (ld) begin
            check("ld_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) check("tx_data", 32'(td), 32'(exp_tx.pop_front()));
        end
        if (err) err_cnt++;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                observe(bus_a.reg_we, bus_a.reg_re, bus_a.tx_load, bus_a.frame_err,
                        bus_a.reg_addr, bus_a.reg_wdata, bus_a.tx_data);
                observe(bus_b.reg_we, bus_b.reg_re, bus_b.tx_load, bus_b.frame_err,
                        bus_b.reg_addr, bus_b.reg_wdata, bus_b.tx_data);
            end
        end
    endtask

    task automatic frame_start();
        exp_tx.push_back(8'hA5);
        ssel = 1'b1;
        tick(3);
    endtask

    task automatic frame_end();
        ssel = 1'b0;
        tick(3);
    endtask

    // One byte with a generous inter-byte gap; drop ends the frame in the same cycle
    task automatic send(input logic [7:0] b, input bit drop = 1'b0);
        rx_data  = b;
        rx_valid = 1'b1;
        if (drop) ssel = 1'b0;
        tick(1);
        rx_valid = 1'b0;
        tick(5);
    endtask

    task automatic write_frame(input logic [6:0] addr, input logic [7:0] data [$], input bit inc);
        logic [6:0] a;
        a = addr;
        frame_start();
        send({1'b0, addr});
        foreach (data[i]) begin
            exp_we.push_back({a, data[i]});
            shadow[a] = data[i];
            send(data[i]);
            if (inc) a = a + 7'd1;
        end
        frame_end();
    endtask

    // Command plus n dummies; the last dummy coincides with the frame drop
    task automatic read_frame(input logic [6:0] addr, input int n);
        logic [6:0] a;
        a = addr;
        frame_start();
        exp_re.push_back(a);
        exp_tx.push_back(shadow[a]);
        send({1'b1, addr});
        for (int i = 0; i < n; i++) begin
            if (i != n - 1) begin
                a = a + 7'd1;
                exp_re.push_back(a);
                exp_tx.push_back(shadow[a]);
            end
            send(8'h00, i == n - 1);
        end
        tick(3);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_data"},   32'(bus_a.tx_data),   32'hA5);
        check({tag, "_tx_load"},   32'(bus_a.tx_load),   32'd0);
        check({tag, "_reg_addr"},  32'(bus_a.reg_addr),  32'd0);
        check({tag, "_reg_wdata"}, 32'(bus_a.reg_wdata), 32'd0);
        check({tag, "_reg_we"},    32'(bus_a.reg_we),    32'd0);
        check({tag, "_reg_re"},    32'(bus_a.reg_re),    32'd0);
        check({tag, "_frame_err"}, 32'(bus_a.frame_err), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        check_reset_values("rst");
        rst_n = 1'b1;
        tick(3);

        // Single write
        write_frame(7'h05, '{8'h3C}, 1'b1);
        check("err_single_write", 32'(err_cnt), 32'(err_exp));

        // Burst write across the wrap, then burst read of the same locations
        write_frame(7'h7E, '{8'h11, 8'h22, 8'h33}, 1'b1);
        read_frame(7'h7E, 3);
        check("err_burst_read", 32'(err_cnt), 32'(err_exp));

        // AUTO_INC = 0 instance: both writes at 0x10
        use_b = 1'b1;
        write_frame(7'h10, '{8'hAA, 8'hBB}, 1'b0);
        use_b = 1'b0;
        check("err_no_inc", 32'(err_cnt), 32'(err_exp));

        // Command-only frame
        frame_start();
        send(8'h12);
        frame_end();
        err_exp++;
        check("err_cmd_only", 32'(err_cnt), 32'(err_exp));

        // Abort during RD_FETCH: the strobe already out, no load follows
        frame_start();
        exp_re.push_back(7'h30);
        rx_data  = 8'hB0;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        ssel     = 1'b0;
        tick(4);
        err_exp++;
        check("err_abort", 32'(err_cnt), 32'(err_exp));
        write_frame(7'h31, '{8'h77}, 1'b1);

        // Reset asserted while in WR_DATA
        frame_start();
        send(8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        ssel = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        write_frame(7'h21, '{8'h5A, 8'hC3}, 1'b1);
        check("err_after_rst", 32'(err_cnt), 32'(err_exp));

        // Everything queued must have been produced
        tick(10);
        check("left_we", 32'(exp_we.size()), 32'd0);
        check("left_re", 32'(exp_re.size()), 32'd0);
        check("left_tx", 32'(exp_tx.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
